// File: rtl/snn_pkg.sv
// Shared SNN definitions: the neuron/source address type and the idle sentinel
// that never matches a real neuron.
package snn_pkg;
  localparam int ADDR_WIDTH = 12;

  typedef logic [ADDR_WIDTH-1:0] addr_t;

  localparam addr_t IDLE_ADDR = 12'hFFF;
endpackage

// File: rtl/spike_dispatcher_if.sv
// Spike ingress handshake from the router plus the broadcast bus to the mac bank.
interface spike_dispatcher_if;
  import snn_pkg::*;

  logic  spike_valid;
  addr_t spike_address;
  logic  spike_ready;
  addr_t source_address;
  logic  source_valid;
  logic  clear;

  modport master (
    output spike_valid, spike_address,
    input  spike_ready, source_address, source_valid, clear
  );

  modport slave (
    input  spike_valid, spike_address,
    output spike_ready, source_address, source_valid, clear
  );
endinterface

// File: rtl/spike_fifo.sv
// Synchronous spike buffer with a combinational head and registered occupancy.
module spike_fifo
  import snn_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic                              CLK,
  input  logic                              RESET,
  input  logic                              push,
  input  logic                              pop,
  input  addr_t                             wdata,
  output addr_t                             head,
  output logic                              full,
  output logic                              empty,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   count
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  addr_t          mem [FIFO_DEPTH];
  logic [PW-1:0]  wptr;
  logic [PW-1:0]  rptr;
  logic           do_push;
  logic           do_pop;

  assign full    = (count == CW'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rptr];

  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (do_push) mem[wptr] <= wdata;
  end
endmodule

// File: rtl/spike_dispatcher.sv
// Buffers router spikes and broadcasts one per dispatch slot to the macs, with
// a clear pulse opening every timestep.
module spike_dispatcher
  import snn_pkg::*;
#(
  parameter int FIFO_DEPTH      = 8,
  parameter int TIMESTEP_CYCLES = 4,
  parameter int TS_WIDTH        = 16
) (
  input  logic                             CLK,
  input  logic                             RESET,
  input  logic                             enable,
  spike_dispatcher_if.slave                bus,
  output logic [TS_WIDTH-1:0]              timestep,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count
);
  localparam int PHW = $clog2(TIMESTEP_CYCLES);

  logic [PHW-1:0]      phase_p0;
  logic [PHW-1:0]      phase_next;
  logic                start_ts;
  logic                push;
  logic                pop;
  logic                full;
  logic                empty;
  addr_t               head;

  logic                clear_p1;
  logic                src_vld_p1;
  addr_t               src_addr_p1;
  logic [TS_WIDTH-1:0] ts_p1;

  // Sentinel addresses are acknowledged but never stored.
  assign push = bus.spike_valid && !full && (bus.spike_address != IDLE_ADDR);

  always_comb begin
    phase_next = (phase_p0 == PHW'(TIMESTEP_CYCLES - 1)) ? '0 : phase_p0 + 1'b1;
    start_ts   = enable && (phase_next == '0);
    pop        = enable && !start_ts && !empty;
  end

  spike_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .CLK   (CLK),
    .RESET (RESET),
    .push  (push),
    .pop   (pop),
    .wdata (bus.spike_address),
    .head  (head),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  // Stage p1: registered broadcast, clear pulse and timestep count.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      phase_p0    <= PHW'(TIMESTEP_CYCLES - 1);
      clear_p1    <= 1'b0;
      src_vld_p1  <= 1'b0;
      src_addr_p1 <= IDLE_ADDR;
      ts_p1       <= '0;
    end else begin
      clear_p1    <= start_ts;
      src_vld_p1  <= pop;
      src_addr_p1 <= pop ? head : IDLE_ADDR;
      if (enable)   phase_p0 <= phase_next;
      if (start_ts) ts_p1    <= ts_p1 + 1'b1;
    end
  end

  assign bus.spike_ready    = !full;
  assign bus.source_address = src_addr_p1;
  assign bus.source_valid   = src_vld_p1;
  assign bus.clear          = clear_p1;
  assign timestep           = ts_p1;
endmodule

// File: tb/tb_spike_dispatcher.sv
// Directed bench for spike_dispatcher: stimulus queues expected dispatches,
// a negedge monitor pops and compares every broadcast spike.
module tb_spike_dispatcher;
  import snn_pkg::*;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        enable = 1'b0;
  logic [15:0] timestep;
  logic [3:0]  fifo_count;

  spike_dispatcher_if bus();

  spike_dispatcher #(
    .FIFO_DEPTH      (8),
    .TIMESTEP_CYCLES (4),
    .TS_WIDTH        (16)
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .enable     (enable),
    .bus        (bus),
    .timestep   (timestep),
    .fifo_count (fifo_count)
  );

  always #5 CLK = ~CLK;

  int    tests = 0;
  int    fails = 0;
  addr_t exp_q[$];
  addr_t mon_e;
  int    ph_m = 3;
  int    ts_m = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  // One clock edge; a tiny phase/timestep model checks clear and timestep.
  task automatic tick();
    @(posedge CLK);
    #1;
    if (RESET) begin
      ph_m = 3;
      ts_m = 0;
    end else if (enable) begin
      ph_m = (ph_m == 3) ? 0 : ph_m + 1;
      if (ph_m == 0) ts_m++;
    end
    chk("clear", {31'd0, bus.clear}, {31'd0, (!RESET && enable && ph_m == 0)});
    chk("timestep", {16'd0, timestep}, ts_m & 32'hFFFF);
  endtask

  task automatic push(input addr_t a, input bit accept);
    bus.spike_valid   = 1'b1;
    bus.spike_address = a;
    tick();
    if (accept) exp_q.push_back(a);
    bus.spike_valid   = 1'b0;
    bus.spike_address = IDLE_ADDR;
  endtask

  always @(negedge CLK) begin
    if (!RESET && bus.source_valid) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_dispatch: got %0d, required no dispatch", bus.source_address);
      end else begin
        mon_e = exp_q.pop_front();
        chk("dispatch_order", {20'd0, bus.source_address}, {20'd0, mon_e});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.spike_valid   = 1'b0;
    bus.spike_address = IDLE_ADDR;

    // Reset
    tick();
    tick();
    RESET = 1'b0;
    tick();
    chk("rst_clear", {31'd0, bus.clear}, 32'd0);
    chk("rst_source_valid", {31'd0, bus.source_valid}, 32'd0);
    chk("rst_source_address", {20'd0, bus.source_address}, 32'hFFF);
    chk("rst_ready", {31'd0, bus.spike_ready}, 32'd1);
    chk("rst_timestep", {16'd0, timestep}, 32'd0);
    chk("rst_count", {28'd0, fifo_count}, 32'd0);

    // Idle run: clears on edges 1, 5, 9
    enable = 1'b1;
    for (int e = 1; e <= 12; e++) tick();
    chk("idle_timestep", {16'd0, timestep}, 32'd3);

    // Ordering and carry-over: pushes start on a clear edge
    push(12'd3, 1'b1);
    chk("ord_valid_e13", {31'd0, bus.source_valid}, 32'd0);
    push(12'd4, 1'b1);
    chk("ord_valid_e14", {31'd0, bus.source_valid}, 32'd1);
    push(12'd5, 1'b1);
    chk("ord_valid_e15", {31'd0, bus.source_valid}, 32'd1);
    push(12'd7, 1'b1);
    chk("ord_valid_e16", {31'd0, bus.source_valid}, 32'd1);
    tick();
    chk("ord_valid_clear", {31'd0, bus.source_valid}, 32'd0);
    chk("ord_count_clear", {28'd0, fifo_count}, 32'd1);
    tick();
    chk("ord_valid_carry", {31'd0, bus.source_valid}, 32'd1);
    chk("ord_addr_carry", {20'd0, bus.source_address}, 32'd7);
    tick();
    chk("ord_valid_e19", {31'd0, bus.source_valid}, 32'd0);
    tick();

    // Sentinel pushed in a dispatch slot
    tick();
    chk("sent_ready", {31'd0, bus.spike_ready}, 32'd1);
    push(IDLE_ADDR, 1'b0);
    chk("sent_count", {28'd0, fifo_count}, 32'd0);
    chk("sent_valid", {31'd0, bus.source_valid}, 32'd0);
    tick();
    chk("sent_valid_next", {31'd0, bus.source_valid}, 32'd0);
    tick();

    // Mid-run reset: 5 queued, phase 2, timestep 7
    enable = 1'b0;
    for (int i = 20; i <= 26; i++) push(addr_t'(i), 1'b1);
    chk("mid_count_loaded", {28'd0, fifo_count}, 32'd7);
    enable = 1'b1;
    tick();
    tick();
    tick();
    chk("mid_count", {28'd0, fifo_count}, 32'd5);
    chk("mid_timestep", {16'd0, timestep}, 32'd7);
    RESET = 1'b1;
    tick();
    exp_q.delete();
    RESET  = 1'b0;
    enable = 1'b0;
    chk("mid_rst_count", {28'd0, fifo_count}, 32'd0);
    chk("mid_rst_timestep", {16'd0, timestep}, 32'd0);
    chk("mid_rst_valid", {31'd0, bus.source_valid}, 32'd0);
    chk("mid_rst_address", {20'd0, bus.source_address}, 32'hFFF);
    chk("mid_rst_ready", {31'd0, bus.spike_ready}, 32'd1);
    enable = 1'b1;
    tick();
    chk("mid_first_clear", {31'd0, bus.clear}, 32'd1);

    // Full: 8 buffered while disabled, 9th refused
    enable = 1'b0;
    for (int i = 10; i <= 17; i++) push(addr_t'(i), 1'b1);
    chk("full_ready", {31'd0, bus.spike_ready}, 32'd0);
    chk("full_count", {28'd0, fifo_count}, 32'd8);
    push(12'd99, 1'b0);
    chk("full_count_after_99", {28'd0, fifo_count}, 32'd8);
    enable = 1'b1;
    tick();
    chk("full_ready_after_pop", {31'd0, bus.spike_ready}, 32'd1);
    chk("full_first_addr", {20'd0, bus.source_address}, 32'd10);
    for (int i = 0; i < 12; i++) tick();
    chk("drain_count", {28'd0, fifo_count}, 32'd0);
    chk("drain_pending", exp_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
